jtframe_dump_ctrl: RTL
======================

// Module: jtframe_dump_ctrl
// PURPOSE
//  Multi-channel, frame-windowed waveform-dump controller for game cores.
//  Counts frames on VS falling edges and drives per-scope dump enables inside
//  programmable frame windows, started either by frame number or by the end of
//  ROM download. Synthesizable; sim wrappers map dump_on/dump_off to $dumpon/$dumpoff.
// PARAMETERS
//  CH   4   number of independent dump channels (scopes)
//  FW   32  frame counter / window width, bits
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      asynchronous active-low reset
//  vs         in   1      vertical sync, active-low, synchronous to clk
//  dwnld      in   1      ROM download in progress (LED signal)
//  arm        in   1      one-cycle pulse: latch cfg_*, (re)start all channels
//  cfg_en     in   CH     channel enable mask
//  cfg_mode   in   CH     per-channel mode: 0=absolute frame, 1=after download
//  cfg_start  in   CH*FW  mode0: start frame; mode1: ignored
//  cfg_stop   in   CH*FW  mode0: stop frame; mode1: window length; 0 = never stop
//  frame_cnt  out  FW     frames since reset
//  dump_en    out  CH     per-channel dump enable
//  dump_on    out  1      pulse: OR(dump_en) rose
//  dump_off   out  1      pulse: OR(dump_en) fell
//  busy       out  1      any channel ARMED or ACTIVE
//  done       out  1      armed once and every enabled channel DONE
// BEHAVIOUR
//  - Reset: frame_cnt=0, dump_en=0, dump_on/off=0, busy=0, done=0, all ch IDLE.
//  - vs_fall = vs_q & ~vs (vs_q = vs registered); dw_fall likewise on dwnld.
//  - frame_cnt += 1 on vs_fall, saturates at all-ones (no wrap).
//  - Window compares use frame_cnt value BEFORE the increment of that edge.
//  - dump_en updates on the same clk edge as frame_cnt: 1 clk after vs seen low.
//  - Per-channel FSM (cfg latched per channel on arm):
//    IDLE   -arm & en-> ARMED ; -arm & ~en-> IDLE
//    ARMED  mode0: vs_fall & frame_cnt==start -> ACTIVE
//           mode0: stop!=0 & start>=stop -> DONE at arm (empty window)
//           mode0: frame_cnt already > start at arm -> DONE (missed window)
//           mode1: seen_dw & vs_fall -> ACTIVE, rel=0; seen_dw sets on
//                  dw_fall; dw_fall and vs_fall in same clk activates at once
//    ACTIVE mode0: vs_fall & stop!=0 & frame_cnt==stop -> DONE
//           mode1: vs_fall increments rel; rel reaching stop (stop!=0) -> DONE
//           stop==0: stays ACTIVE until arm or reset
//    DONE   holds until arm
//    dump_en[i] = (state==ACTIVE). Window is [start, stop) frames.
//  - arm in any state: every channel reloads cfg and restarts (ACTIVE->ARMED
//    drops dump_en next clk); frame_cnt is NOT cleared; seen_dw cleared.
//  - dump_on/dump_off: registered edge of OR(dump_en); exactly 1 clk wide;
//    never both high. Two channels overlapping -> single on/off pair.
//  - done: set when armed-once flag & all en channels DONE; cleared by arm.
//    arm with cfg_en=0 -> done=1 the next clk, busy=0.
//  - cfg_* sampled only on arm; changes otherwise ignored.
// STRUCTURE
//  - Package jtframe_dump_pkg: ch_state_t {IDLE,ARMED,ACTIVE,DONE},
//    MODE_FRAME=1'b0, MODE_DWNLD=1'b1.
//  - Sub-module jtframe_dump_ch (one FSM, cfg latch, rel counter), generated
//    CH times; top holds edge detect, frame counter, aggregation, pulses.
// TESTING
//  - CH=2, ch0 mode0 start=3 stop=5 -> dump_en[0] high frames 3..4, 1 clk after
//    4th/6th vs fall; dump_on/off one pulse each.
//  - ch0 mode1 stop=2; dwnld 1->0 at frame 7 -> dump_en[0] rises at next vs
//    fall, falls 2 vs falls later; done=1 next clk.
//  - ch0 [2,6) ch1 [4,8) -> dump_on once at 2, dump_off once at 8, busy=0 after.
//  - start=4 stop=4 -> DONE at arm, dump_en never rises; start=1 armed at
//    frame 10 -> DONE, done=1.
//  - rst_n low while ACTIVE -> all outputs 0 asynchronously; arm mid-window
//    -> dump_en drops next clk, dump_off pulse, window re-evaluated.
//  - FW=4, 20 vs falls -> frame_cnt saturates at 15; stop=0 ch stays ACTIVE.

Source files
------------

// File: rtl/jtframe_dump_pkg.sv
// Shared types and constants for the frame-windowed dump controller.
package jtframe_dump_pkg;

  typedef enum logic [1:0] {
    CH_IDLE   = 2'd0,
    CH_ARMED  = 2'd1,
    CH_ACTIVE = 2'd2,
    CH_DONE   = 2'd3
  } ch_state_t;

  localparam logic MODE_FRAME = 1'b0;
  localparam logic MODE_DWNLD = 1'b1;

  // True when a channel no longer holds the controller busy.
  function automatic logic ch_settled(input ch_state_t st);
    return (st == CH_IDLE) || (st == CH_DONE);
  endfunction

endpackage

// File: rtl/jtframe_dump_ch.sv
// One dump channel: configuration latch, window FSM and relative frame counter.
module jtframe_dump_ch
  import jtframe_dump_pkg::*;
#(
  parameter int FW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          arm_i,
  input  logic          cfg_en_i,
  input  logic          cfg_mode_i,
  input  logic [FW-1:0] cfg_start_i,
  input  logic [FW-1:0] cfg_stop_i,
  input  logic [FW-1:0] frame_cnt_i,
  input  logic          vs_fall_i,
  input  logic          dw_fall_i,
  output ch_state_t     state_o,
  output logic          dump_en_o
);

  ch_state_t     state_q;
  logic          mode_q;
  logic [FW-1:0] start_q;
  logic [FW-1:0] stop_q;
  logic [FW-1:0] rel_q;
  logic          seen_dw_q;
  logic          dump_en_q;
  logic [FW-1:0] rel_inc_s;
  logic          stop_set_s;

  assign rel_inc_s  = rel_q + {{(FW-1){1'b0}}, 1'b1};
  assign stop_set_s = (stop_q != {FW{1'b0}});

  // Window FSM; arm reloads the configuration in any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CH_IDLE;
      mode_q    <= MODE_FRAME;
      start_q   <= {FW{1'b0}};
      stop_q    <= {FW{1'b0}};
      rel_q     <= {FW{1'b0}};
      seen_dw_q <= 1'b0;
      dump_en_q <= 1'b0;
    end else if (arm_i) begin
      mode_q    <= cfg_mode_i;
      start_q   <= cfg_start_i;
      stop_q    <= cfg_stop_i;
      rel_q     <= {FW{1'b0}};
      seen_dw_q <= 1'b0;
      dump_en_q <= 1'b0;
      if (!cfg_en_i) begin
        state_q <= CH_IDLE;
      end else if ((cfg_mode_i == MODE_FRAME) &&
                   (((cfg_stop_i != {FW{1'b0}}) && (cfg_start_i >= cfg_stop_i)) ||
                    (frame_cnt_i > cfg_start_i))) begin
        // Empty window or start frame already passed: nothing to dump.
        state_q <= CH_DONE;
      end else begin
        state_q <= CH_ARMED;
      end
    end else begin
      case (state_q)
        CH_ARMED: begin
          if (mode_q == MODE_FRAME) begin
            if (vs_fall_i && (frame_cnt_i == start_q)) begin
              state_q   <= CH_ACTIVE;
              dump_en_q <= 1'b1;
            end else if (frame_cnt_i > start_q) begin
              state_q <= CH_DONE;
            end else begin
              state_q <= CH_ARMED;
            end
          end else begin
            if (dw_fall_i) begin
              seen_dw_q <= 1'b1;
            end else begin
              seen_dw_q <= seen_dw_q;
            end
            // Download end and frame edge in the same clock start at once.
            if ((seen_dw_q || dw_fall_i) && vs_fall_i) begin
              state_q   <= CH_ACTIVE;
              dump_en_q <= 1'b1;
              rel_q     <= {FW{1'b0}};
            end else begin
              state_q <= CH_ARMED;
            end
          end
        end
        CH_ACTIVE: begin
          if (vs_fall_i) begin
            if (mode_q == MODE_FRAME) begin
              if (stop_set_s && (frame_cnt_i == stop_q)) begin
                state_q   <= CH_DONE;
                dump_en_q <= 1'b0;
              end else begin
                state_q <= CH_ACTIVE;
              end
            end else begin
              rel_q <= rel_inc_s;
              if (stop_set_s && (rel_inc_s == stop_q)) begin
                state_q   <= CH_DONE;
                dump_en_q <= 1'b0;
              end else begin
                state_q <= CH_ACTIVE;
              end
            end
          end else begin
            state_q <= CH_ACTIVE;
          end
        end
        default: begin
          // IDLE and DONE hold until the next arm.
          state_q <= state_q;
        end
      endcase
    end
  end

  assign state_o   = state_q;
  assign dump_en_o = dump_en_q;

endmodule

// File: rtl/jtframe_dump_ctrl.sv
// Frame-windowed multi-channel dump controller: edge detect, frame counter,
// per-channel windows and aggregated on/off/busy/done status.
module jtframe_dump_ctrl
  import jtframe_dump_pkg::*;
#(
  parameter int CH = 4,
  parameter int FW = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           vs,
  input  logic           dwnld,
  input  logic           arm,
  input  logic [CH-1:0]    cfg_en,
  input  logic [CH-1:0]    cfg_mode,
  input  logic [CH*FW-1:0] cfg_start,
  input  logic [CH*FW-1:0] cfg_stop,
  output logic [FW-1:0]  frame_cnt,
  output logic [CH-1:0]  dump_en,
  output logic           dump_on,
  output logic           dump_off,
  output logic           busy,
  output logic           done
);

  logic          vs_q;
  logic          dw_q;
  logic [FW-1:0] frame_q;
  logic [FW-1:0] frame_d;
  logic          any_q;
  logic          dump_on_q;
  logic          dump_off_q;
  logic          busy_q;
  logic          done_q;
  logic          armed_q;

  logic          vs_fall_s;
  logic          dw_fall_s;
  logic          any_en_s;
  logic          busy_s;
  logic [CH-1:0] dump_en_s;
  ch_state_t     st_s [CH];

  assign vs_fall_s = vs_q & ~vs;
  assign dw_fall_s = dw_q & ~dwnld;
  assign any_en_s  = |dump_en_s;

  // Frame counter next value: count VS falls, hold at all-ones.
  always_comb begin
    frame_d = frame_q;
    if (vs_fall_s && (frame_q != {FW{1'b1}})) begin
      frame_d = frame_q + {{(FW-1){1'b0}}, 1'b1};
    end else begin
      frame_d = frame_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      jtframe_dump_ch #(.FW(FW)) u_ch (
        .clk         (clk),
        .rst_n       (rst_n),
        .arm_i       (arm),
        .cfg_en_i    (cfg_en[gi]),
        .cfg_mode_i  (cfg_mode[gi]),
        .cfg_start_i (cfg_start[gi*FW +: FW]),
        .cfg_stop_i  (cfg_stop[gi*FW +: FW]),
        .frame_cnt_i (frame_q),
        .vs_fall_i   (vs_fall_s),
        .dw_fall_i   (dw_fall_s),
        .state_o     (st_s[gi]),
        .dump_en_o   (dump_en_s[gi])
      );
    end
  endgenerate

  // Any channel still waiting for or inside its window.
  always_comb begin
    busy_s = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (!ch_settled(st_s[i])) begin
        busy_s = 1'b1;
      end else begin
        busy_s = busy_s;
      end
    end
  end

  // Edge detectors, frame counter and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q       <= 1'b1;
      dw_q       <= 1'b0;
      frame_q    <= {FW{1'b0}};
      any_q      <= 1'b0;
      dump_on_q  <= 1'b0;
      dump_off_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      vs_q       <= vs;
      dw_q       <= dwnld;
      frame_q    <= frame_d;
      any_q      <= any_en_s;
      dump_on_q  <= any_en_s & ~any_q;
      dump_off_q <= ~any_en_s & any_q;
      busy_q     <= busy_s;
      if (arm) begin
        armed_q <= 1'b1;
        done_q  <= 1'b0;
      end else begin
        armed_q <= armed_q;
        done_q  <= armed_q & ~busy_s;
      end
    end
  end

  assign frame_cnt = frame_q;
  assign dump_en   = dump_en_s;
  assign dump_on   = dump_on_q;
  assign dump_off  = dump_off_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
